tick_div_chain: RTL and testbench
=================================

TICK_DIV_CHAIN -- requirements
Module: tick_div_chain

Interface
REQ-001 SHALL provide parameter NUM_CH, default 3, number of cascaded divider channels (1..8).
REQ-002 SHALL provide parameter CNT_W, default 16, per-channel counter and divisor width.
REQ-003 SHALL provide parameter DIV_INIT, default {16'd60,16'd60,16'd1000}, packed NUM_CH*CNT_W reset divisors, channel 0 in LSBs.
REQ-004 SHALL provide port clock  input  1  clock.
REQ-005 SHALL provide port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port enable  input  1  high = channel 0 advances each clock; low = whole chain holds.
REQ-007 SHALL provide port clear  input  1  synchronous restart of all channels.
REQ-008 SHALL provide port ld_valid  input  1  divisor load request.
REQ-009 SHALL provide port ld_ch  input  CH_W=max(1,clog2(NUM_CH))  target channel.
REQ-010 SHALL provide port ld_div  input  CNT_W  new divisor.
REQ-011 SHALL provide port ld_ready  output  1  load slot free.
REQ-012 SHALL provide port ld_err  output  1  one-cycle pulse for a rejected load.
REQ-013 SHALL provide port tick  output  NUM_CH  per-channel one-cycle wrap pulse.
REQ-014 SHALL provide port sq_out  output  NUM_CH  per-channel square wave (see REQ-030).

Function
REQ-015 Channel k SHALL advance when enable=1 and, for k=0, every clock; for k>0, only in cycles where tick[k-1]=1.
REQ-016 On advance, cnt[k] SHALL increment; when cnt[k]==div[k]-1 it SHALL wrap to 0 and tick[k] SHALL be 1 the next cycle. tick[k] SHALL be 0 in all other cycles.
REQ-017 Latency: tick[k] SHALL occur one clock after the advancing cycle in which cnt[k] wrapped, giving one extra clock of latency per stage.
REQ-018 Period: with enable held high, tick[0] SHALL pulse every div[0] clocks; tick[k] SHALL pulse every product(div[0..k]) clocks.
REQ-019 div=1 SHALL make the channel tick on every advance.
REQ-020 enable=0 SHALL freeze all counters and force tick to 0; a tick pulse already due in the current cycle SHALL still be issued.
REQ-021 The handshake SHALL accept a load on ld_valid & ld_ready. ld_ready SHALL be 1 when no load is pending and 0 while one is pending.
REQ-022 An accepted load with ld_div==0 or ld_ch>=NUM_CH SHALL be discarded, SHALL pulse ld_err the next cycle, and SHALL leave ld_ready at 1.
REQ-023 A valid accepted load SHALL be held pending and applied to div[ld_ch] in the cycle that channel wraps. The wrap itself SHALL use the old divisor, and the next cycle SHALL count against the new divisor. ld_ready SHALL return to 1 the cycle after the apply.
REQ-024 clear=1 SHALL set all cnt to 0, tick to 0 and sq_out to 0, and SHALL immediately apply any pending load. clear SHALL take priority over enable and over a simultaneous wrap.
REQ-025 A load arriving in the same cycle as clear SHALL be accepted and become pending, not applied.
REQ-026 Counter arithmetic SHALL be modulo div and SHALL never exceed div-1. If the stored cnt is >= div because of a smaller divisor, cnt SHALL wrap on its next advance.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 reset=0 SHALL asynchronously set: cnt=0, tick=0, sq_out=0, ld_err=0, ld_ready=1, pending cleared, div[k]=DIV_INIT slice k.
REQ-029 Deasserting reset mid-count SHALL restart the chain from 0; a load pending at reset SHALL be lost.

Configuration
REQ-030 With macro TICK_DIV_SQUARE_OUT_EN defined, sq_out[k] SHALL be registered as (cnt_next[k] >= div[k]>>1). For even divisors this gives 50% duty; for odd divisors it is high one count longer; for div=1 it is constant 1 after the first advance.
REQ-031 With TICK_DIV_SQUARE_OUT_EN undefined, sq_out SHALL be tied to 0 and SHALL have no comparator logic.

Verification
REQ-032 Scenario: defaults, enable=1 for 120000 clocks -> tick[0] every 1000 clocks, tick[1] every 60000 clocks, first tick[1] 60001 clocks after enable.
REQ-033 Scenario: load ch0 div=4 mid-count at cnt=500 -> ld_ready=0 until the wrap at cnt 999; then tick[0] every 4 clocks; ld_ready=1 the next cycle.
REQ-034 Scenario: load div=0 and load ch=3 -> each gives one ld_err pulse; divisors unchanged; ld_ready stays 1.
REQ-035 Scenario: clear asserted with a pending ch1 div=10 load -> counters 0, new divisor active immediately; tick[1] every 10000 clocks.
REQ-036 Scenario: enable toggled 0 for 37 clocks at ch0 cnt=998 -> ch0 holds 998; tick[0] is 2 clocks after re-enable.
REQ-037 Scenario: TICK_DIV_SQUARE_OUT_EN defined, ch0 div=5 -> sq_out[0] low 2 counts, high 3 counts, repeating; undefined -> sq_out stays 0.

Source files
------------

// File: rtl/tick_div_chain.sv
// Cascade of programmable tick dividers with a single-slot divisor load port.
// Square-wave outputs are built only when TICK_DIV_SQUARE_OUT_EN is defined.
module tick_div_chain #(
    parameter int NUM_CH = 3,
    parameter int CNT_W = 16,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd60, 16'd60, 16'd1000},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              ld_valid,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [CNT_W-1:0]  ld_div,
    output logic              ld_ready,
    output logic              ld_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq_out
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  div      [NUM_CH];
    logic [CNT_W-1:0]  cnt_next [NUM_CH];
    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply_sel;
    logic [CH_W-1:0]   pend_ch;
    logic [CNT_W-1:0]  pend_div;
    logic              pending;
    logic              accept;
    logic              bad_load;
    logic              apply_hit;

    // ld_ready doubles as the "slot empty" flag so it is a true flop output.
    assign pending  = ~ld_ready;
    assign accept   = ld_valid & ld_ready;
    assign bad_load = (ld_div == '0) || ({1'b0, ld_ch} >= NUM_CH_L);

    always_comb begin
        adv       = '0;
        wrap      = '0;
        apply_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_next[k] = cnt[k];
            if (k == 0)
                adv[k] = enable;
            else
                adv[k] = enable & tick[(k == 0) ? 0 : k-1];
            // >= rather than == so a count left above a shrunken divisor still wraps.
            wrap[k]      = (cnt[k] >= div[k] - CNT_W'(1));
            apply_sel[k] = pending && (pend_ch == CH_W'(k));
            if (adv[k])
                cnt_next[k] = wrap[k] ? '0 : cnt[k] + CNT_W'(1);
        end
        apply_hit = |(apply_sel & adv & wrap);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
                div[k] <= DIV_INIT[k*CNT_W +: CNT_W];
            end
            tick     <= '0;
            ld_ready <= 1'b1;
            ld_err   <= 1'b0;
            pend_ch  <= '0;
            pend_div <= '0;
        end else begin
            ld_err <= 1'b0;
            if (clear) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    cnt[k] <= '0;
                    if (apply_sel[k])
                        div[k] <= pend_div;
                end
                tick     <= '0;
                ld_ready <= 1'b1;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    cnt[k]  <= cnt_next[k];
                    tick[k] <= adv[k] & wrap[k];
                    if (apply_sel[k] && adv[k] && wrap[k])
                        div[k] <= pend_div;
                end
                if (apply_hit)
                    ld_ready <= 1'b1;
            end
            // Acceptance only happens with the slot empty, so it never races the apply above.
            if (accept) begin
                if (bad_load) begin
                    ld_err <= 1'b1;
                end else begin
                    ld_ready <= 1'b0;
                    pend_ch  <= ld_ch;
                    pend_div <= ld_div;
                end
            end
        end
    end

`ifdef TICK_DIV_SQUARE_OUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sq_out <= '0;
        end else if (clear) begin
            sq_out <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (adv[k])
                    sq_out[k] <= (cnt_next[k] >= (div[k] >> 1));
            end
        end
    end
`else
    assign sq_out = '0;
`endif

endmodule

// File: tb/tb_tick_div_chain.sv
// Directed self-checking bench for tick_div_chain with default parameters.
module tb_tick_div_chain;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       ld_valid;
    logic [1:0] ld_ch;
    logic [15:0] ld_div;
    logic       ld_ready;
    logic       ld_err;
    logic [2:0] tick;
    logic [2:0] sq_out;

    int checks = 0;
    int errors = 0;

    tick_div_chain dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .clear(clear),
        .ld_valid(ld_valid),
        .ld_ch(ld_ch),
        .ld_div(ld_div),
        .ld_ready(ld_ready),
        .ld_err(ld_err),
        .tick(tick),
        .sq_out(sq_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < limit);
    endtask

    task automatic load(input logic [1:0] ch, input logic [15:0] dv);
        ld_valid = 1'b1;
        ld_ch    = ch;
        ld_div   = dv;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; clear = 1'b0;
        ld_valid = 1'b0; ld_ch = '0; ld_div = '0;
        step(); step();
        checks++; if (tick !== 3'b000)  begin errors++; $display("[TB] FAIL reset_tick got %b expected 000", tick); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", ld_ready); end
        checks++; if (ld_err !== 1'b0)   begin errors++; $display("[TB] FAIL reset_err got %b expected 0", ld_err); end
        checks++; if (sq_out !== 3'b000) begin errors++; $display("[TB] FAIL reset_sq got %b expected 000", sq_out); end
        reset = 1'b1;
    endtask

    task automatic test_default_period();
        int n;
        enable = 1'b1;
        wait_tick(0, 1100, n);
        checks++; if (n !== 1000) begin errors++; $display("[TB] FAIL first_tick0 got %0d expected 1000", n); end
        wait_tick(0, 1100, n);
        checks++; if (n !== 1000) begin errors++; $display("[TB] FAIL period_tick0 got %0d expected 1000", n); end
        checks++; if (tick[1] !== 1'b0) begin errors++; $display("[TB] FAIL tick1_early got %b expected 0", tick[1]); end
        step();
        checks++; if (tick[0] !== 1'b0) begin errors++; $display("[TB] FAIL tick0_width got %b expected 0", tick[0]); end
    endtask

    task automatic test_enable_hold();
        int n;
        bit seen = 0;
        repeat (997) step();
        enable = 1'b0;
        repeat (37) begin
            step();
            if (tick !== 3'b000) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL hold_tick got %b expected 0", seen); end
        enable = 1'b1;
        wait_tick(0, 10, n);
        checks++; if (n !== 2) begin errors++; $display("[TB] FAIL reenable_tick got %0d expected 2", n); end
    endtask

    task automatic test_load_midcount();
        int n;
        bit ready_ok = 1;
        repeat (500) step();
        load(2'd0, 16'd4);
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_busy got %b expected 0", ld_ready); end
        checks++; if (ld_err !== 1'b0)   begin errors++; $display("[TB] FAIL load_err got %b expected 0", ld_err); end
        n = 0;
        do begin
            step();
            n++;
            if (!tick[0] && ld_ready) ready_ok = 0;
        end while (!tick[0] && n < 600);
        checks++; if (n !== 499)        begin errors++; $display("[TB] FAIL apply_wrap got %0d expected 499", n); end
        checks++; if (ready_ok !== 1'b1) begin errors++; $display("[TB] FAIL ready_held got %b expected 1", ready_ok); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_back got %b expected 1", ld_ready); end
        wait_tick(0, 20, n);
        checks++; if (n !== 4) begin errors++; $display("[TB] FAIL div4_period_a got %0d expected 4", n); end
        wait_tick(0, 20, n);
        checks++; if (n !== 4) begin errors++; $display("[TB] FAIL div4_period_b got %0d expected 4", n); end
    endtask

    task automatic test_bad_loads();
        int n;
        load(2'd0, 16'd0);
        checks++; if (ld_err !== 1'b1)   begin errors++; $display("[TB] FAIL err_div0 got %b expected 1", ld_err); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_div0 got %b expected 1", ld_ready); end
        step();
        checks++; if (ld_err !== 1'b0)   begin errors++; $display("[TB] FAIL err_pulse got %b expected 0", ld_err); end
        load(2'd3, 16'd7);
        checks++; if (ld_err !== 1'b1)   begin errors++; $display("[TB] FAIL err_ch3 got %b expected 1", ld_err); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_ch3 got %b expected 1", ld_ready); end
        wait_tick(0, 20, n);
        wait_tick(0, 20, n);
        checks++; if (n !== 4) begin errors++; $display("[TB] FAIL div_kept got %0d expected 4", n); end
    endtask

    task automatic test_div_one();
        int n;
        load(2'd0, 16'd1);
        wait_tick(0, 20, n);
        wait_tick(0, 20, n);
        checks++; if (n !== 1) begin errors++; $display("[TB] FAIL div1_period got %0d expected 1", n); end
        wait_tick(1, 200, n);
        wait_tick(1, 200, n);
        checks++; if (n !== 60) begin errors++; $display("[TB] FAIL chain_period got %0d expected 60", n); end
    endtask

    task automatic test_square_out();
        int n;
        logic exp_sq;
        load(2'd0, 16'd5);
        wait_tick(0, 20, n);
        wait_tick(0, 20, n);
        checks++; if (n !== 5) begin errors++; $display("[TB] FAIL div5_period got %0d expected 5", n); end
        for (int k = 1; k <= 10; k++) begin
            step();
`ifdef TICK_DIV_SQUARE_OUT_EN
            exp_sq = ((k % 5) >= 2);
            checks++; if (sq_out[0] !== exp_sq) begin errors++; $display("[TB] FAIL sq_step%0d got %b expected %b", k, sq_out[0], exp_sq); end
`else
            exp_sq = 1'b0;
            checks++; if (sq_out !== {3{exp_sq}}) begin errors++; $display("[TB] FAIL sq_off%0d got %b expected 000", k, sq_out); end
`endif
        end
    endtask

    task automatic test_reset_midcount();
        int n;
        load(2'd2, 16'd3);
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_before_rst got %b expected 0", ld_ready); end
        #3 reset = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_ready got %b expected 1", ld_ready); end
        checks++; if (tick !== 3'b000)   begin errors++; $display("[TB] FAIL async_tick got %b expected 000", tick); end
        step(); step();
        reset = 1'b1;
        wait_tick(0, 1100, n);
        checks++; if (n !== 1000) begin errors++; $display("[TB] FAIL restart_tick got %0d expected 1000", n); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL pend_lost got %b expected 1", ld_ready); end
    endtask

    task automatic test_clear_pending();
        int n;
        load(2'd1, 16'd10);
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_ch1 got %b expected 0", ld_ready); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (tick !== 3'b000)   begin errors++; $display("[TB] FAIL clear_tick got %b expected 000", tick); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_apply got %b expected 1", ld_ready); end
        checks++; if (sq_out !== 3'b000) begin errors++; $display("[TB] FAIL clear_sq got %b expected 000", sq_out); end
        wait_tick(1, 10100, n);
        checks++; if (n !== 10001) begin errors++; $display("[TB] FAIL first_tick1 got %0d expected 10001", n); end
        wait_tick(1, 10100, n);
        checks++; if (n !== 10000) begin errors++; $display("[TB] FAIL period_tick1 got %0d expected 10000", n); end
    endtask

    task automatic test_clear_with_load();
        int n;
        clear = 1'b1;
        load(2'd0, 16'd8);
        clear = 1'b0;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_load_pend got %b expected 0", ld_ready); end
        checks++; if (tick !== 3'b000)   begin errors++; $display("[TB] FAIL clr_load_tick got %b expected 000", tick); end
        wait_tick(0, 1100, n);
        checks++; if (n !== 1000) begin errors++; $display("[TB] FAIL old_div_used got %0d expected 1000", n); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL clr_load_ready got %b expected 1", ld_ready); end
        wait_tick(0, 20, n);
        checks++; if (n !== 8) begin errors++; $display("[TB] FAIL div8_period got %0d expected 8", n); end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_enable_hold();
        test_load_midcount();
        test_bad_loads();
        test_div_one();
        test_square_out();
        test_reset_midcount();
        test_clear_pending();
        test_clear_with_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
